// File: rtl/pp_requant_pkg.sv
// Shared types and constants for the requant/pack stage.
package pp_requant_pkg;

  localparam int PP_IN_W      = 21;
  localparam int PP_OUT_W     = 8;
  localparam int PP_DIM_W     = 12;
  localparam int PP_SHIFT_MAX = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Sideband flags that ride alongside each pixel through the pipe and FIFO
  typedef struct packed {
    logic user;
    logic last;
  } flags_t;

  // Half-LSB rounding constant for a right shift of 'shift' bits
  function automatic logic [PP_IN_W:0] rnd_const(input logic [4:0] shift);
    logic [PP_IN_W:0] r;
    r = '0;
    if (shift != 5'd0) r[shift - 5'd1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/pp_requant_fifo.sv
// Small synchronous FIFO with registered storage and an occupancy count.
// Read data is presented from the head entry whenever the FIFO is non-empty.
module pp_requant_fifo #(
  parameter  int W     = 10,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
)(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         valid,
  output logic [AW:0]  count
);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [AW-1:0]           wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]             cnt_q, cnt_d;
  logic                    do_push, do_pop;

  // Next-state for storage, pointers and count; push+pop together keeps count
  always_comb begin
    do_pop  = pop && (cnt_q != '0);
    do_push = push && ((cnt_q != (AW+1)'(DEPTH)) || do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = wdata;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) rd_d = rd_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; storage is cleared too so the output reads 0 after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign rdata = mem_q[rd_q];
  assign valid = (cnt_q != '0);
  assign count = cnt_q;

endmodule

// File: rtl/pp_pipeline_accel_requant_pack.sv
// Requant/pack stage behind the 8x13+15 muladd: round, shift, saturate each
// MAC result to an OUT_W pixel and stream it out with SOF (user) / EOL (last).
// Optional feature macro: PP_REQUANT_SATCNT_EN adds a saturation counter port.
// din_ready is built from registers only, since it also gates the muladd ce.
module pp_pipeline_accel_requant_pack
  import pp_requant_pkg::*;
#(
  parameter int IN_W       = PP_IN_W,
  parameter int OUT_W      = PP_OUT_W,
  parameter int DIM_W      = PP_DIM_W,
  parameter int FIFO_DEPTH = 4
)(
  input  logic             clk,
  input  logic             reset,
`ifdef PP_REQUANT_SATCNT_EN
  output logic [15:0]      sat_count,
`endif
  input  logic             start,
  input  logic [4:0]       cfg_shift,
  input  logic [DIM_W-1:0] cfg_cols,
  input  logic [DIM_W-1:0] cfg_rows,
  input  logic             din_valid,
  input  logic [IN_W-1:0]  din,
  output logic             din_ready,
  output logic             dout_valid,
  output logic [OUT_W-1:0] dout,
  output logic             dout_user,
  output logic             dout_last,
  input  logic             dout_ready,
  output logic             busy,
  output logic             done
);

  localparam int SUM_W = IN_W + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int REM_W = 2 * DIM_W;
  localparam logic [SUM_W-1:0] PIX_MAX = SUM_W'((1 << OUT_W) - 1);
  localparam logic [CNT_W:0]   DEPTH_V = (CNT_W+1)'(FIFO_DEPTH);

  state_t             state_q, state_d;
  logic [4:0]         shift_q, shift_d;
  logic [DIM_W-1:0]   cols_q, cols_d, col_q, col_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic               first_q, first_d, done_q, done_d;
  logic [1:0]         vld_pipe_q, vld_pipe_d;   // [0]=S1, [1]=S2
  logic [SUM_W-1:0]   sum1_q, sum1_d;
  flags_t             flg1_q, flg1_d, flg2_q, flg2_d;
  logic [OUT_W-1:0]   pix2_q, pix2_d;
`ifdef PP_REQUANT_SATCNT_EN
  logic [15:0]        sat_q, sat_d;
`endif
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W:0]     occupancy;
  logic [SUM_W-1:0]   q2;
  logic               sat2, accept, line_end;
  logic [OUT_W+1:0]   fifo_rdata;

  // Accept only while every sample in flight already owns a FIFO slot
  always_comb begin
    occupancy = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(vld_pipe_q[0]) +
                (CNT_W+1)'(vld_pipe_q[1]);
    din_ready = (state_q == RUN) && (rem_q != '0) && (occupancy < DEPTH_V);
  end

  assign accept   = din_valid && din_ready;
  assign line_end = (col_q == cols_q - DIM_W'(1));
  assign q2       = sum1_q >> shift_q;
  assign sat2     = (q2 > PIX_MAX);

  // Frame FSM, counters and the two datapath stages
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cols_d     = cols_q;
    col_d      = col_q;
    rem_d      = rem_q;
    first_d    = first_q;
    done_d     = 1'b0;
    vld_pipe_d = {vld_pipe_q[0], accept};
    sum1_d     = sum1_q;
    flg1_d     = flg1_q;
    pix2_d     = pix2_q;
    flg2_d     = flg2_q;
`ifdef PP_REQUANT_SATCNT_EN
    sat_d      = sat_q;
    if (vld_pipe_q[0] && sat2 && (sat_q != 16'hFFFF)) sat_d = sat_q + 16'd1;
`endif

    case (state_q)
      IDLE: if (start) begin
        shift_d = (cfg_shift > 5'(PP_SHIFT_MAX)) ? 5'(PP_SHIFT_MAX) : cfg_shift;
        cols_d  = cfg_cols;
        rem_d   = REM_W'(cfg_cols) * REM_W'(cfg_rows);
        col_d   = '0;
        first_d = 1'b1;
        // Empty frame goes straight to DRAIN so done still follows start
        state_d = ((cfg_cols == '0) || (cfg_rows == '0)) ? DRAIN : RUN;
`ifdef PP_REQUANT_SATCNT_EN
        sat_d   = '0;
`endif
      end
      RUN: if (accept) begin
        rem_d   = rem_q - REM_W'(1);
        col_d   = line_end ? '0 : col_q + DIM_W'(1);
        first_d = 1'b0;
        if (rem_q == REM_W'(1)) state_d = DRAIN;
      end
      DRAIN: if ((vld_pipe_q == '0) && (fifo_count == '0)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // S1: add the rounding constant; flags are captured with the sample
    if (accept) begin
      sum1_d      = {1'b0, din} + SUM_W'(rnd_const(shift_q));
      flg1_d.user = first_q;
      flg1_d.last = line_end;
    end
    // S2: shift and clip to the pixel range
    if (vld_pipe_q[0]) begin
      pix2_d = sat2 ? '1 : q2[OUT_W-1:0];
      flg2_d = flg1_q;
    end
  end

  // All state registers, cleared by the asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cols_q     <= '0;
      col_q      <= '0;
      rem_q      <= '0;
      first_q    <= 1'b0;
      done_q     <= 1'b0;
      vld_pipe_q <= '0;
      sum1_q     <= '0;
      flg1_q     <= '0;
      pix2_q     <= '0;
      flg2_q     <= '0;
`ifdef PP_REQUANT_SATCNT_EN
      sat_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cols_q     <= cols_d;
      col_q      <= col_d;
      rem_q      <= rem_d;
      first_q    <= first_d;
      done_q     <= done_d;
      vld_pipe_q <= vld_pipe_d;
      sum1_q     <= sum1_d;
      flg1_q     <= flg1_d;
      pix2_q     <= pix2_d;
      flg2_q     <= flg2_d;
`ifdef PP_REQUANT_SATCNT_EN
      sat_q      <= sat_d;
`endif
    end
  end

  pp_requant_fifo #(
    .W     (OUT_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (vld_pipe_q[1]),
    .wdata ({flg2_q.user, flg2_q.last, pix2_q}),
    .pop   (dout_ready),
    .rdata (fifo_rdata),
    .valid (dout_valid),
    .count (fifo_count)
  );

  assign dout      = fifo_rdata[OUT_W-1:0];
  assign dout_last = fifo_rdata[OUT_W];
  assign dout_user = fifo_rdata[OUT_W+1];
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
`ifdef PP_REQUANT_SATCNT_EN
  assign sat_count = sat_q;
`endif

endmodule
